paint_stamp_ctrl: RTL
=====================

# paint_stamp_ctrl

- Sequences brush "stamps" into the shared 160x120, 3-bit-per-pixel framebuffer RAM.
- Arbitrates that single-port RAM between stamp writes and the VGA scan-out reader.
- Sits between the user-input logic (X_POS, Y_POS, color, tool_on, size_sel) and the framebuffer; the 640x480 VGA controller reads pixels through it.
- Video reads always win; stamp writes stall and never drop.

## Interface
- FB_W, 160, framebuffer width in pixels
- FB_H, 120, framebuffer height in pixels
- ADDR_W, 15, framebuffer address width
- SCALE_SH, 2, right shift from 640x480 screen coordinates to framebuffer coordinates

- clk  in  1  master clock, 100 MHz
- clr  in  1  reset, asynchronous, active-high
- X_POS  in  10  cursor x, screen coordinates
- Y_POS  in  10  cursor y, screen coordinates
- color  in  3  brush colour
- tool_on  in  1  brush down
- size_sel  in  1  0 = 2x2 brush, 1 = 4x4 brush (framebuffer pixels)
- vid_req  in  1  video read request, one cycle per pixel
- vid_addr  in  ADDR_W  video read address
- vid_valid  out  1  vid_rdata valid (one cycle after vid_req)
- vid_rdata  out  3  video read data
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  3  RAM write data
- mem_rdata  in  3  RAM read data, synchronous, 1-cycle latency
- busy  out  1  stamp in progress
- stamp_done  out  1  one-cycle pulse after the last footprint slot

## Operation
- Centre coordinates: cx = min(X_POS>>SCALE_SH, FB_W-1), cy = min(Y_POS>>SCALE_SH, FB_H-1).
- Brush size N = 2 (size_sel=0) or 4 (size_sel=1).
- Footprint origin: (cx-N/2, cy-N/2), computed as signed 11-bit values.
- Address = y*FB_W + x, computed as (y<<7)+(y<<5)+x.
- FSM states:
  - IDLE -> LATCH when tool_on=1 and {cx, cy, color, size_sel} differs from the last-stamped register. A held brush at a fixed spot never rewrites.
  - LATCH (1 cycle): registers cx, cy, color, N, and the origin. Clears dx and dy. Updates the last-stamped register.
  - STAMP: steps through N*N slots in row-major order, dx fastest.
    - A slot advances only in cycles with vid_req=0.
    - In-bounds slot: mem_we=1, mem_addr = pixel address, mem_wdata = latched colour.
    - Out-of-bounds slot (BRUSH_CLIP_EN only): consumes the cycle with mem_we=0.
    - After the last slot -> DONE.
  - DONE (1 cycle): stamp_done=1 -> IDLE.
- Inputs changing during LATCH, STAMP or DONE are ignored.
- tool_on falling mid-stamp does not abort the stamp.
- The last-stamped register holds a valid bit, cleared by clr and set in LATCH. When the valid bit is clear, any tool_on=1 triggers a stamp.
- Video arbitration:
  - vid_req=1: mem_addr = vid_addr and mem_we=0 in the same cycle, with absolute priority.
  - Next cycle: vid_valid=1, and vid_rdata = mem_rdata (combinational pass-through).
  - vid_rdata = 0 whenever vid_valid=0.
- busy = 1 in LATCH, STAMP and DONE.
- clr at any time, including mid-stamp, immediately returns the block to reset state. No further writes occur; the partial stamp is not resumed.

## Timing
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, vid_valid=0, vid_rdata=0, busy=0, stamp_done=0, FSM=IDLE, last-stamped valid bit=0.
- Trigger detected in cycle T -> LATCH in T+1 -> first slot in T+2.
- With no video contention, the last slot is in T+1+N*N and stamp_done is in T+2+N*N.
- Each vid_req cycle during STAMP adds exactly one cycle of latency.
- Video read latency is always exactly 1 cycle. Back-to-back vid_req is supported at 1 pixel/cycle.
- vid_req together with a pending stamp slot: the video read proceeds and the slot is held with its dx/dy unchanged.

## Configuration
- BRUSH_CLIP_EN defined:
  - Footprint pixels with x<0, x>=FB_W, y<0 or y>=FB_H are skipped; each still consumes one slot.
  - Stamp length is always N*N slots.
- BRUSH_CLIP_EN undefined:
  - The origin is clamped to [0, FB_W-N] x [0, FB_H-N], so the brush shifts inward.
  - All N*N slots write.

## Test plan
- Reset: assert clr with tool_on=1 -> all outputs 0. Release -> exactly one stamp starts (LATCH in the cycle after trigger detection).
- 2x2 stamp, X_POS=100, Y_POS=40, color=5, size_sel=0, no vid_req -> mem_we on 4 consecutive cycles:
  - addresses 1464, 1465, 1624, 1625, wdata=5;
  - stamp_done 1 cycle after the last write;
  - tool_on held with unchanged inputs -> no further writes.
- Corner 4x4 stamp, X_POS=0, Y_POS=0, size_sel=1:
  - with BRUSH_CLIP_EN -> writes only to addresses 0, 1, 160, 161 over 16 slots;
  - without it -> 16 writes to 0-3, 160-163, 320-323, 480-483.
- Contention: vid_req=1 with vid_addr=777 during the 2nd slot of the 2x2 stamp:
  - that cycle mem_addr=777, mem_we=0;
  - next cycle vid_valid=1 and vid_rdata = model RAM content;
  - the 2nd write (1465) follows;
  - all 4 writes are present and stamp_done is delayed by 1 cycle.
- Retrigger: tool_on held, color changes 5->2 after stamp_done -> a new 2x2 stamp writes colour 2 to the same 4 addresses.
- Mid-stamp clr during the 4x4 stamp after 3 writes -> no further mem_we, busy=0 immediately, and no stamp_done.

Source files
------------

// File: rtl/paint_stamp_ctrl.sv
// -----------------------------------------------------------------------------
// paint_stamp_ctrl
//
// Writes square brush "stamps" into a shared 160x120, 3-bit-per-pixel
// single-port framebuffer RAM. It also shares that RAM with the VGA scan-out
// reader, and video reads always win the port.
//
// Optional build macro:
//   BRUSH_CLIP_EN  Defined: footprint pixels outside the framebuffer are
//                  skipped, but each one still takes a slot.
//                  Undefined: the origin is clamped so the whole brush fits.
//
// Handshake (video side): vid_req is a one-cycle request with no ready signal.
// It is always accepted in the cycle it is raised. vid_valid follows exactly
// one cycle later, together with vid_rdata. vid_rdata is forced to 0 whenever
// vid_valid is low.
//
// Ports:
//   clk, clr            clock, asynchronous active-high reset
//   X_POS, Y_POS        cursor position in 640x480 screen coordinates
//   color, tool_on      brush colour, brush down
//   size_sel            0 = 2x2 brush, 1 = 4x4 brush
//   vid_req, vid_addr   video read request and address
//   vid_valid, vid_rdata  video read response
//   mem_addr, mem_we, mem_wdata, mem_rdata  framebuffer RAM port
//   busy, stamp_done    stamp in progress; one-cycle completion pulse
//   state_dbg           current FSM state (IDLE=0, LATCH=1, STAMP=2, DONE=3)
// -----------------------------------------------------------------------------
module paint_stamp_ctrl #(
    parameter int FB_W     = 160,
    parameter int FB_H     = 120,
    parameter int ADDR_W   = 15,
    parameter int SCALE_SH = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [9:0]        X_POS,
    input  logic [9:0]        Y_POS,
    input  logic [2:0]        color,
    input  logic              tool_on,
    input  logic              size_sel,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_valid,
    output logic [2:0]        vid_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [2:0]        mem_wdata,
    input  logic [2:0]        mem_rdata,
    output logic              busy,
    output logic              stamp_done,
    output logic [1:0]        state_dbg
);

    // The coordinate widths are sized for a 160x120 framebuffer.
    localparam int CX_W  = 8;
    localparam int CY_W  = 7;
    localparam int KEY_W = CX_W + CY_W + 3 + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        STAMP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    // Centre of the brush in framebuffer coordinates, clamped to the last pixel.
    logic [9:0]      x_sh, y_sh;
    logic [CX_W-1:0] cx;
    logic [CY_W-1:0] cy;

    assign x_sh = X_POS >> SCALE_SH;
    assign y_sh = Y_POS >> SCALE_SH;
    assign cx   = (x_sh > 10'(FB_W - 1)) ? CX_W'(FB_W - 1) : x_sh[CX_W-1:0];
    assign cy   = (y_sh > 10'(FB_H - 1)) ? CY_W'(FB_H - 1) : y_sh[CY_W-1:0];

    // Footprint origin, signed so that brushes near the top/left edge can go negative.
    logic signed [10:0] half_s, ox_raw, oy_raw, ox_new, oy_new;
`ifndef BRUSH_CLIP_EN
    logic signed [10:0] ox_max, oy_max;
`endif

    always_comb begin
        half_s = size_sel ? 11'sd2 : 11'sd1;
        ox_raw = $signed({3'b000, cx}) - half_s;
        oy_raw = $signed({4'b0000, cy}) - half_s;
`ifdef BRUSH_CLIP_EN
        ox_new = ox_raw;
        oy_new = oy_raw;
`else
        // Shift the brush inward so that every slot lands on a real pixel.
        ox_max = $signed(11'(FB_W)) - (half_s <<< 1);
        oy_max = $signed(11'(FB_H)) - (half_s <<< 1);
        ox_new = ox_raw;
        oy_new = oy_raw;
        if (ox_raw < 11'sd0)
            ox_new = 11'sd0;
        else if (ox_raw > ox_max)
            ox_new = ox_max;
        if (oy_raw < 11'sd0)
            oy_new = 11'sd0;
        else if (oy_raw > oy_max)
            oy_new = oy_max;
`endif
    end

    // The last-stamped key suppresses rewrites while the brush is held still.
    logic [KEY_W-1:0] cur_key, last_key;
    logic             last_valid;
    logic             trigger;

    assign cur_key = {cx, cy, color, size_sel};
    assign trigger = tool_on && (!last_valid || (cur_key != last_key));

    // Stamp context latched in LATCH.
    logic [2:0]         l_color;
    logic               l_size;
    logic signed [10:0] org_x, org_y;
    logic [1:0]         dx, dy;
    logic [1:0]         nm1;
    logic signed [10:0] px, py;
    logic               in_bounds;
    logic               last_slot;
    logic               advance;
    logic [ADDR_W-1:0]  pix_addr;

    assign nm1       = l_size ? 2'd3 : 2'd1;
    assign px        = org_x + $signed({9'b0, dx});
    assign py        = org_y + $signed({9'b0, dy});
    // In the clamped build this is always true. The check remains so that both
    // builds share one write path.
    assign in_bounds = (px >= 11'sd0) && (px < $signed(11'(FB_W))) &&
                       (py >= 11'sd0) && (py < $signed(11'(FB_H)));
    assign last_slot = (dx == nm1) && (dy == nm1);
    // y*160 + x, using shifts only.
    assign pix_addr  = (ADDR_W'(py[6:0]) << 7) + (ADDR_W'(py[6:0]) << 5) + ADDR_W'(px[7:0]);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= IDLE;
            vid_valid  <= 1'b0;
            last_valid <= 1'b0;
            last_key   <= '0;
            l_color    <= 3'd0;
            l_size     <= 1'b0;
            org_x      <= 11'sd0;
            org_y      <= 11'sd0;
            dx         <= 2'd0;
            dy         <= 2'd0;
        end else begin
            state     <= state_next;
            vid_valid <= vid_req;
            if (state == LATCH) begin
                l_color    <= color;
                l_size     <= size_sel;
                org_x      <= ox_new;
                org_y      <= oy_new;
                dx         <= 2'd0;
                dy         <= 2'd0;
                last_key   <= cur_key;
                last_valid <= 1'b1;
            end else if (advance) begin
                if (dx == nm1) begin
                    dx <= 2'd0;
                    dy <= dy + 2'd1;
                end else begin
                    dx <= dx + 2'd1;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        advance    = 1'b0;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = 3'd0;
        stamp_done = 1'b0;
        case (state)
            IDLE:  if (trigger) state_next = LATCH;
            LATCH: state_next = STAMP;
            STAMP: begin
                // A slot is held, with dx/dy unchanged, in any cycle that the video reader owns the port.
                if (!vid_req) begin
                    advance = 1'b1;
                    if (in_bounds) begin
                        mem_we    = 1'b1;
                        mem_addr  = pix_addr;
                        mem_wdata = l_color;
                    end
                    if (last_slot)
                        state_next = DONE;
                end
            end
            DONE: begin
                stamp_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (vid_req) begin
            mem_addr  = vid_addr;
            mem_we    = 1'b0;
            mem_wdata = 3'd0;
        end
    end

    assign vid_rdata = vid_valid ? mem_rdata : 3'd0;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule
